monolith_sponge: RTL and testbench

MONOLITH_SPONGE -- requirements
Module: monolith_sponge

---
 rtl/monolith_sponge.sv | 110 +++++++++++
 tb/tb_monolith_sponge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/monolith_sponge.sv
// Sponge wrapper around an external Monolith permutation core over GF(2^31-1).
// Absorbs RATE words per block, pads the final block on the last lane, squeezes OUT_WORDS words.
module monolith_sponge #(
  parameter int WORD_WIDTH = 31,
  parameter int STATE_SIZE = 16,
  parameter int RATE       = 8,
  parameter int OUT_WORDS  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  perm_reset,
  output logic [WORD_WIDTH-1:0] perm_state_out [0:STATE_SIZE-1],
  input  logic [WORD_WIDTH-1:0] perm_state_in  [0:STATE_SIZE-1],
  input  logic                  perm_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int LW = (STATE_SIZE > 1) ? $clog2(STATE_SIZE) : 1;
  localparam int IW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int OW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [WORD_WIDTH-1:0] P = '1;

  typedef enum logic [1:0] {ABSORB, PERM_START, PERM_WAIT, SQUEEZE} fsm_e;

  fsm_e                  fsm_q, fsm_d;
  logic [WORD_WIDTH-1:0] st_q [0:STATE_SIZE-1];
  logic [WORD_WIDTH-1:0] st_d [0:STATE_SIZE-1];
  logic [IW-1:0]         idx_q, idx_d;
  logic [OW-1:0]         oidx_q, oidx_d;
  logic                  last_q, last_d;

  // Both operands are < p, so one conditional subtract fully reduces the sum.
  function automatic logic [WORD_WIDTH-1:0] addp(input logic [WORD_WIDTH-1:0] a,
                                                 input logic [WORD_WIDTH-1:0] b);
    logic [WORD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P}) s = s - {1'b0, P};
    return s[WORD_WIDTH-1:0];
  endfunction

  always_comb begin
    fsm_d  = fsm_q;
    st_d   = st_q;
    idx_d  = idx_q;
    oidx_d = oidx_q;
    last_d = last_q;
    case (fsm_q)
      ABSORB: if (in_valid) begin
        // The all-ones encoding is congruent to zero mod p.
        st_d[LW'(idx_q)] = addp(st_q[LW'(idx_q)], (in_data == P) ? '0 : in_data);
        if (in_last) begin
          st_d[STATE_SIZE-1] = addp(st_q[STATE_SIZE-1], WORD_WIDTH'(1));
          last_d = 1'b1;
        end
        if (idx_q == IW'(RATE-1) || in_last) begin
          fsm_d = PERM_START;
          idx_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      PERM_START: fsm_d = PERM_WAIT;
      PERM_WAIT: if (perm_valid) begin
        st_d  = perm_state_in;
        idx_d = '0;
        fsm_d = last_q ? SQUEEZE : ABSORB;
      end
      SQUEEZE: if (out_ready) begin
        if (oidx_q == OW'(OUT_WORDS-1)) begin
          st_d   = '{default: '0};
          last_d = 1'b0;
          oidx_d = '0;
          fsm_d  = ABSORB;
        end else begin
          oidx_d = oidx_q + OW'(1);
        end
      end
      default: fsm_d = ABSORB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= ABSORB;
      st_q   <= '{default: '0};
      idx_q  <= '0;
      oidx_q <= '0;
      last_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      st_q   <= st_d;
      idx_q  <= idx_d;
      oidx_q <= oidx_d;
      last_q <= last_d;
    end
  end

  assign perm_state_out = st_q;
  assign in_ready       = (fsm_q == ABSORB);
  assign perm_reset     = (fsm_q != PERM_WAIT);
  assign out_valid      = (fsm_q == SQUEEZE);
  assign out_data       = out_valid ? st_q[LW'(oidx_q)] : '0;
  assign out_last       = out_valid && (oidx_q == OW'(OUT_WORDS-1));
endmodule

// File: tb/tb_monolith_sponge.sv
// Directed bench for monolith_sponge with an identity permutation stub
// whose result becomes valid three cycles after perm_reset falls.
module tb_monolith_sponge;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, out_ready, perm_valid;
  logic [30:0] in_data;
  logic        in_ready, perm_reset, out_valid, out_last;
  logic [30:0] out_data;
  logic [30:0] perm_state_out [0:15];
  logic [30:0] perm_state_in  [0:15];

  int nchk = 0, nfail = 0;
  int scnt = 0, windows = 0;
  bit stub_hold = 1'b0, pr_d = 1'b1;
  logic [30:0] dig [8];
  logic        dv [8], dl [8];
  logic [30:0] ex [8];
  logic [30:0] el [16];

  monolith_sponge dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .perm_reset(perm_reset),
    .perm_state_out(perm_state_out), .perm_state_in(perm_state_in),
    .perm_valid(perm_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (perm_reset) scnt <= 0;
    else if (scnt < 3) scnt <= scnt + 1;
    pr_d <= perm_reset;
    if (pr_d && !perm_reset) windows <= windows + 1;
  end
  assign perm_valid    = (scnt == 3) && !stub_hold;
  assign perm_state_in = perm_state_out;

  task automatic send(input logic [30:0] d, input bit l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      nchk++; nfail++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic get_digest();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin
      nchk++; nfail++;
      $display("FAIL digest_timeout: out_valid=%0b required 1", out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      dv[i] = out_valid; dig[i] = out_data; dl[i] = out_last;
      @(posedge clk);
    end
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    nchk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || perm_reset !== 1'b1 ||
        out_last !== 1'b0 || out_data !== 31'd0) begin
      nfail++;
      $display("FAIL reset_ctrl: rdy=%0b ov=%0b pr=%0b ol=%0b od=%0h required 1 0 1 0 0",
               in_ready, out_valid, perm_reset, out_last, out_data);
    end
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (perm_state_out[i] !== 31'd0) begin
        nfail++;
        $display("FAIL reset_lane%0d: got %0h required 0", i, perm_state_out[i]);
      end
    end
  endtask

  task automatic test_single();
    send(31'd5, 1'b1);
    @(negedge clk);
    nchk++;
    if (in_ready !== 1'b0 || perm_reset !== 1'b1) begin
      nfail++;
      $display("FAIL single_start: rdy=%0b pr=%0b required 0 1", in_ready, perm_reset);
    end
    el = '{default: '0}; el[0] = 31'd5; el[15] = 31'd1;
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (perm_state_out[i] !== el[i]) begin
        nfail++;
        $display("FAIL single_lane%0d: got %0h required %0h", i, perm_state_out[i], el[i]);
      end
    end
    @(negedge clk);
    nchk++;
    if (perm_reset !== 1'b0 || in_ready !== 1'b0) begin
      nfail++;
      $display("FAIL single_wait: pr=%0b rdy=%0b required 0 0", perm_reset, in_ready);
    end
    get_digest();
    ex = '{default: '0}; ex[0] = 31'd5;
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (dig[i] !== ex[i] || dv[i] !== 1'b1 || dl[i] !== (i == 7)) begin
        nfail++;
        $display("FAIL single_dig%0d: got %0h v%0b l%0b required %0h v1 l%0b",
                 i, dig[i], dv[i], dl[i], ex[i], (i == 7));
      end
    end
  endtask

  task automatic test_modadd();
    send(31'h7FFF_FFFE, 1'b0);
    for (int i = 1; i < 8; i++) send(31'd0, 1'b0);
    send(31'd3, 1'b1);
    get_digest();
    ex = '{default: '0}; ex[0] = 31'd2;
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (dig[i] !== ex[i] || dl[i] !== (i == 7)) begin
        nfail++;
        $display("FAIL modadd_dig%0d: got %0h l%0b required %0h", i, dig[i], dl[i], ex[i]);
      end
    end
    send(31'h7FFF_FFFF, 1'b0);
    send(31'd4, 1'b1);
    @(negedge clk);
    nchk++;
    if (perm_state_out[0] !== 31'd0 || perm_state_out[1] !== 31'd4 ||
        perm_state_out[15] !== 31'd1) begin
      nfail++;
      $display("FAIL modadd_zero: lanes0/1/15=%0h %0h %0h required 0 4 1",
               perm_state_out[0], perm_state_out[1], perm_state_out[15]);
    end
    get_digest();
    ex = '{default: '0}; ex[1] = 31'd4;
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (dig[i] !== ex[i]) begin
        nfail++;
        $display("FAIL modadd_zdig%0d: got %0h required %0h", i, dig[i], ex[i]);
      end
    end
  endtask

  task automatic test_exact_block();
    int w0;
    w0 = windows;
    for (int i = 1; i <= 8; i++) send(31'(i), i == 8);
    @(negedge clk);
    nchk++;
    if (perm_state_out[15] !== 31'd1 || perm_state_out[7] !== 31'd8) begin
      nfail++;
      $display("FAIL exact_pad: lane15=%0h lane7=%0h required 1 8",
               perm_state_out[15], perm_state_out[7]);
    end
    get_digest();
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (dig[i] !== 31'(i + 1) || dl[i] !== (i == 7)) begin
        nfail++;
        $display("FAIL exact_dig%0d: got %0h l%0b required %0h", i, dig[i], dl[i], i + 1);
      end
    end
    repeat (3) @(negedge clk);
    nchk++;
    if (windows - w0 !== 1 || in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL exact_windows: windows=%0d rdy=%0b required 1 1", windows - w0, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    send(31'd5, 1'b1);
    @(negedge clk);
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    for (int c = 0; c < 10; c++) begin
      nchk++;
      if (out_valid !== 1'b1 || out_data !== 31'd5 || out_last !== 1'b0 || in_ready !== 1'b0) begin
        nfail++;
        $display("FAIL bp_hold%0d: ov=%0b od=%0h ol=%0b rdy=%0b required 1 5 0 0",
                 c, out_valid, out_data, out_last, in_ready);
      end
      @(negedge clk);
    end
    get_digest();
    ex = '{default: '0}; ex[0] = 31'd5;
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (dv[i] !== 1'b1 || dig[i] !== ex[i] || dl[i] !== (i == 7)) begin
        nfail++;
        $display("FAIL bp_dig%0d: got %0h v%0b l%0b required %0h v1", i, dig[i], dv[i], dl[i], ex[i]);
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    stub_hold = 1'b1;
    send(31'd9, 1'b1);
    @(negedge clk);
    while (perm_reset && n < 20) begin @(negedge clk); n++; end
    nchk++;
    if (perm_reset !== 1'b0) begin
      nfail++;
      $display("FAIL rw_enter: pr=%0b required 0", perm_reset);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    stub_hold = 1'b0;
    @(negedge clk);
    nchk++;
    if (perm_reset !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        perm_state_out[0] !== 31'd0 || perm_state_out[15] !== 31'd0) begin
      nfail++;
      $display("FAIL rw_after: pr=%0b ov=%0b rdy=%0b l0=%0h l15=%0h required 1 0 1 0 0",
               perm_reset, out_valid, in_ready, perm_state_out[0], perm_state_out[15]);
    end
    send(31'd5, 1'b1);
    get_digest();
    ex = '{default: '0}; ex[0] = 31'd5;
    for (int i = 0; i < 8; i++) begin
      nchk++;
      if (dig[i] !== ex[i] || dl[i] !== (i == 7)) begin
        nfail++;
        $display("FAIL rw_dig%0d: got %0h l%0b required %0h", i, dig[i], dl[i], ex[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_modadd();
    test_exact_block();
    test_backpressure();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
